// File: rtl/nibble_serial_adder.sv
// Digit-serial adder: one 4-bit digit per cycle using a conditional-sum nibble
// stage, wrapped in an IDLE/ADD/DONE valid-ready handshake.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   ci,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   co
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t               r_state;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [W-1:0]         r_s;
    logic                 r_carry;
    logic                 r_co;
    logic                 r_out_valid;
    logic [IDX_W-1:0]     r_idx;

    logic [3:0]           w_a_nib;
    logic [3:0]           w_b_nib;
    logic [4:0]           w_nib_sum;

    // Both carry candidates are built up front; the carry register only drives the final mux.
    function automatic logic [4:0] csel_add(input logic [3:0] x, input logic [3:0] y,
                                            input logic cin);
        logic [4:0] sum0;
        logic [4:0] sum1;
        sum0 = {1'b0, x} + {1'b0, y};
        sum1 = sum0 + 5'd1;
        return cin ? sum1 : sum0;
    endfunction

    assign w_a_nib   = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib   = r_b[{r_idx, 2'b00} +: 4];
    assign w_nib_sum = csel_add(w_a_nib, w_b_nib, r_carry);

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign co        = r_co;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_carry     <= 1'b0;
            r_co        <= 1'b0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ci;
                        r_idx   <= '0;
                        r_s     <= '0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_s[{r_idx, 2'b00} +: 4] <= w_nib_sum[3:0];
                    r_carry                  <= w_nib_sum[4];
                    if (r_idx == LAST_IDX) begin
                        r_co        <= w_nib_sum[4];
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES; NIBBLES >= 2 SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  W  addend A, sampled only on acceptance.
REQ-007 b  input  W  addend B, sampled only on acceptance.
REQ-008 ci  input  1  carry-in, sampled only on acceptance.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 s  output  W  registered sum.
REQ-012 co  output  1  registered carry-out.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, ADD and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE and SHALL be decoded from state, with no dependence on in_valid.
REQ-015 Acceptance SHALL occur on an edge with in_valid=1 in IDLE: latch a, b into operand registers, carry register <= ci, digit index <= 0, s <= 0, next state ADD.
REQ-016 In IDLE with in_valid=0, the FSM SHALL stay in IDLE and s/co SHALL hold their last values.
REQ-017 Each ADD cycle SHALL process digit idx: sum nibble = a[4idx+3:4idx] + b[4idx+3:4idx] + carry, with both carry-0 and carry-1 candidate sums formed and one chosen by the carry register (conditional-sum form).
REQ-018 Each ADD edge SHALL write the chosen nibble into s[4idx+3:4idx], load the nibble carry-out into the carry register, and increment idx.
REQ-019 On the ADD edge with idx = NIBBLES-1, the FSM SHALL also set co <= final carry, out_valid <= 1 and next state DONE.
REQ-020 Latency: out_valid SHALL rise exactly NIBBLES edges after the acceptance edge.
REQ-021 Result SHALL equal (a + b + ci) mod 2^W, with co = bit W of the full sum.
REQ-022 In DONE, out_valid SHALL be 1 and s and co SHALL be held stable until the handshake completes.
REQ-023 In DONE, in_valid SHALL be ignored.
REQ-024 On an edge in DONE with out_ready=1: out_valid <= 0, next state IDLE, s/co retained; in_ready SHALL be 1 in the following cycle.
REQ-025 With out_ready held at 1, sustained throughput SHALL be one operation per NIBBLES+2 cycles.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 in_valid, a, b and ci SHALL be ignored outside the IDLE acceptance edge; changes during ADD SHALL NOT affect the result.
REQ-028 idx SHALL be ceil(log2(NIBBLES)) bits wide.
REQ-029 idx SHALL be reset to 0 on entry to ADD and SHALL never index beyond NIBBLES-1.

Reset
REQ-030 On rst=1, the block SHALL immediately, without waiting for a clock edge, set: state IDLE, in_ready 1, out_valid 0, s 0, co 0, carry 0, idx 0, operand registers 0.
REQ-031 rst asserted during ADD or DONE SHALL abort the operation with no out_valid pulse; the first acceptance is possible on the first edge after rst deasserts.

Verification (NIBBLES=4)
REQ-032 Basic add: a=0x1234, b=0x4321, ci=0 -> s=0x5555, co=0, with out_valid rising 4 edges after acceptance.
REQ-033 Full ripple: a=0xFFFF, b=0x0000, ci=1 -> s=0x0000, co=1.
REQ-034 Backpressure: a=0x8000, b=0x8000, ci=0, out_ready=0 for 5 cycles -> s=0x0000, co=1, out_valid held; in_ready=0 throughout; in_valid pulses with a=0x1111 ignored, result unchanged.
REQ-035 Mid-op reset: rst pulsed after 2 ADD edges of 0x0F0F+0x0101 -> out_valid=0, s=0, in_ready=1 asynchronously; a following 0x0001+0x0001 gives s=0x0002.
REQ-036 Back-to-back: out_ready=1, in_valid=1 constant, 0x00FF+0x0001 (ci=0) -> s=0x0100, co=0; then 0xABCD+0x1111 (ci=1) -> s=0xBCDF, co=0; second acceptance 6 cycles after the first.
REQ-037 Input stability: a and b are changed on every ADD cycle after acceptance of 0x7777+0x0889 -> s=0x8000, co=0.
